// File: rtl/mmio_timer_responder.sv
// Memory-mapped down-counter timer answering the core's data-side
// device handshake (d_ready stall, one-cycle d_valid completion).
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   addr, wdata         : access address and store data from MEM stage
//   mem_store_type      : 00 none, 01 byte, 10 word, 11 dword
//   mem_load_type       : same encoding; ignored when a store is present
//   d_ready             : access claimed / in progress (core stalls)
//   d_valid             : access complete, d_rdata valid this cycle
//   d_rdata             : lane-extracted load result, 0 when not valid
//   irq                 : registered STATUS.pending & CTRL.ie
module mmio_timer_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_FFFF_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [1:0]  mem_store_type,
    input  logic [1:0]  mem_load_type,
    output logic        d_ready,
    output logic        d_valid,
    output logic [63:0] d_rdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [4:0]  off_q;
    logic [63:0] wdata_q;
    logic [1:0]  type_q;
    logic        store_q;

    logic        en_q, ie_q, rl_q, pending_q, irq_q;
    logic        en_d, ie_d, rl_d, pending_d, irq_d;
    logic [63:0] count_q, reload_q, count_d, reload_d;

    logic        hit, take, commit;
    logic [63:0] reg_view, merged, wbits;

    // Place the store data into its lane of an existing 64-bit value.
    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] wd,
                                          input logic [1:0]  t,
                                          input logic [2:0]  o);
        logic [63:0] m;
        logic [63:0] d;
        m = '0;
        d = '0;
        unique case (t)
            2'b01: begin
                m = 64'hFF << {o, 3'b000};
                d = {56'b0, wd[7:0]} << {o, 3'b000};
            end
            2'b10: begin
                m = 64'hFFFF_FFFF << {o[2], 5'b00000};
                d = {32'b0, wd[31:0]} << {o[2], 5'b00000};
            end
            2'b11: begin
                m = '1;
                d = wd;
            end
            default: ;
        endcase
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] v,
                                            input logic [1:0]  t,
                                            input logic [2:0]  o);
        logic [63:0] r;
        r = '0;
        unique case (t)
            2'b01:   r = (v >> {o, 3'b000}) & 64'hFF;
            2'b10:   r = (v >> {o[2], 5'b00000}) & 64'hFFFF_FFFF;
            2'b11:   r = v;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign hit = (addr[63:5] == BASE_ADDR[63:5]) &&
                 ((mem_store_type != 2'b00) || (mem_load_type != 2'b00));

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        d_ready = 1'b0;
        d_valid = 1'b0;
        take    = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                d_ready = hit;
                if (hit) begin
                    take    = 1'b1;
                    lat_d   = LAT_INIT;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                d_ready = 1'b1;
                lat_d   = lat_q - 4'd1;
                if (lat_q <= 4'd1) state_d = RESP;
            end
            RESP: begin
                d_valid = 1'b1;
                commit  = store_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reg_view = '0;
        unique case (off_q[4:3])
            2'd0: reg_view = {61'b0, rl_q, ie_q, en_q};
            2'd1: reg_view = count_q;
            2'd2: reg_view = reload_q;
            2'd3: reg_view = {63'b0, pending_q};
        endcase
    end

    assign merged = merge(reg_view, wdata_q, type_q, off_q[2:0]);
    // Only the bits actually written count for W1C, not untouched lanes.
    assign wbits  = merge(64'b0, wdata_q, type_q, off_q[2:0]);

    assign d_rdata = (d_valid && !store_q) ?
                     extract(reg_view, type_q, off_q[2:0]) : 64'b0;

    always_comb begin
        en_d      = en_q;
        ie_d      = ie_q;
        rl_d      = rl_q;
        count_d   = count_q;
        reload_d  = reload_q;
        pending_d = pending_q;
        if (en_q) begin
            if (count_q != 64'b0) begin
                count_d = count_q - 64'd1;
            end else if (rl_q) begin
                count_d = reload_q;
            end else begin
                en_d = 1'b0;
            end
        end
        if (commit && off_q[4:3] == 2'd3 && wbits[0]) pending_d = 1'b0;
        // Terminal count after the W1C so a coincident set wins.
        if (en_q && count_q == 64'b0) pending_d = 1'b1;
        // Bus stores come last so they override the timer's own update.
        if (commit) begin
            unique case (off_q[4:3])
                2'd0: {rl_d, ie_d, en_d} = merged[2:0];
                2'd1: count_d  = merged;
                2'd2: reload_d = merged;
                2'd3: ;
            endcase
        end
        irq_d = pending_d & ie_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            type_q    <= '0;
            store_q   <= 1'b0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            rl_q      <= 1'b0;
            count_q   <= '0;
            reload_q  <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            if (take) begin
                off_q   <= addr[4:0];
                wdata_q <= wdata;
                store_q <= (mem_store_type != 2'b00);
                type_q  <= (mem_store_type != 2'b00) ?
                           mem_store_type : mem_load_type;
            end
            en_q      <= en_d;
            ie_q      <= ie_d;
            rl_q      <= rl_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule
